single_cycle_cpu: RTL and testbench
===================================

// Module: single_cycle_cpu
// PURPOSE
//   Single-cycle 32-bit MIPS subset processor, top level of the design.
//   Each clk cycle fetches one instruction, decodes it, executes it and writes back.
//   Contains PC, a 32x32 register file and one unified word memory (text + data).
//   Instance/signal names PC, instruction, regfile.reg0..reg31 and MEMORY.mem are
//   fixed; benches preload and inspect them hierarchically.
// PARAMETERS
//   MEM_WORDS   4096   depth of unified memory, 32-bit words
//   DATA_BASE   2048   word index where the .data segment starts (byte 0x2000)
// PORTS
//   clk    input  1  system clock; all state updates on rising edge
//   reset  input  1  synchronous, active-high; forces PC to 0
// BEHAVIOUR
//   - Reset: on posedge clk with reset=1, PC<=0. Registers and memory are not cleared.
//     PC also powers up as 0; all 32 registers power up as 0.
//   - Memory: MEMORY.mem[0:MEM_WORDS-1] x 32 bits, word-indexed by byte address [13:2].
//     .text loads at word 0, .data at DATA_BASE.
//     Two combinational read ports: instruction fetch at PC, data at ALU result.
//     Write port is synchronous: on posedge when MemWrite=1.
//   - instruction = mem[PC[13:2]], combinational.
//   - Register file: regfile.reg0..reg31. Two combinational read ports.
//     One write port, written on posedge when RegWrite=1. reg0 is always 0.
//     Writes to register 0 are ignored.
//   - PC update each non-reset edge:
//     - default PC+4
//     - beq/bne taken: PC+4+(sext(imm16)<<2)
//     - j/jal: {PC+4[31:28], target26, 2'b00}
//     - jr: rs
//   - Instructions (all others are a NOP that advances PC by 4):
//     - R-type (op 0): add funct 0x20 (rd=rs+rt), sub 0x22 (rd=rs-rt),
//       slt 0x2A (rd = signed rs<rt ? 1 : 0), jr 0x08.
//     - addi 0x08: rt = rs + sext(imm).
//     - xori 0x0E: rt = rs ^ zext(imm).
//     - lw 0x23: rt = mem[rs+sext(imm)].
//     - sw 0x2B: mem[rs+sext(imm)] = rt.
//     - beq 0x04, bne 0x05: compare rs and rt.
//     - j 0x02, jal 0x03: jal writes PC+4 into reg31.
//   - Arithmetic is 32-bit two's complement wrap-around; no overflow traps.
//   - Unaligned addresses: low 2 bits are ignored.
//   - Write-back source mux: ALU result, memory data (lw) or PC+4 (jal).
//   - Latency: an instruction's results are visible after the edge that ends its cycle.
//     A dependent instruction in the next cycle reads the new value.
// TESTING
//   - Reset/fetch: reset high for one edge -> PC=0.
//     Then PC advances 0,4,8,... every 20 ns clock; instruction = mem[PC/4].
//   - ALU program: addi $16,$0,5; addi $17,$0,5; sub $18,$16,$17; add $19,$16,$17;
//     slt $20,$16,$17 -> reg16=5, reg17=5, reg18=0, reg19=10, reg20=0, reg21=0.
//   - Jump/link: jal at address 12 -> reg31=16 and PC=target.
//     Function body does add/addi giving reg18=25 and reg25=20, then jr $31 returns to 16.
//     reg20 stays 0.
//   - Branches: beq $16,$17 with equal values (5,5) is taken and skips an
//     addi $19,$0,1 -> reg19=0. bne with equal values falls through.
//     Final reg18=10, reg20=0.
//   - Memory: addi $8,$0,0x2000; addi $9,$0,42; sw $9,4($8); lw $10,4($8)
//     -> mem[2049]=42, reg10=42.
//   - Zero register: addi $0,$0,7 -> reg0 still 0.
//     xori $11,$0,0xFFFF -> reg11=65535 (zero-extended).

Source files
------------

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS subset: PC, 32x32 register file and a unified text/data word memory.
// Each clock edge retires exactly one instruction.

module regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] reg0;
  logic [31:0] reg1 = '0, reg2 = '0, reg3 = '0, reg4 = '0, reg5 = '0, reg6 = '0, reg7 = '0;
  logic [31:0] reg8 = '0, reg9 = '0, reg10 = '0, reg11 = '0, reg12 = '0, reg13 = '0;
  logic [31:0] reg14 = '0, reg15 = '0, reg16 = '0, reg17 = '0, reg18 = '0, reg19 = '0;
  logic [31:0] reg20 = '0, reg21 = '0, reg22 = '0, reg23 = '0, reg24 = '0, reg25 = '0;
  logic [31:0] reg26 = '0, reg27 = '0, reg28 = '0, reg29 = '0, reg30 = '0, reg31 = '0;

  assign reg0 = '0;

  always_ff @(posedge clk) begin
    if (we) begin
      case (waddr)
        5'd1:  reg1  <= wdata;
        5'd2:  reg2  <= wdata;
        5'd3:  reg3  <= wdata;
        5'd4:  reg4  <= wdata;
        5'd5:  reg5  <= wdata;
        5'd6:  reg6  <= wdata;
        5'd7:  reg7  <= wdata;
        5'd8:  reg8  <= wdata;
        5'd9:  reg9  <= wdata;
        5'd10: reg10 <= wdata;
        5'd11: reg11 <= wdata;
        5'd12: reg12 <= wdata;
        5'd13: reg13 <= wdata;
        5'd14: reg14 <= wdata;
        5'd15: reg15 <= wdata;
        5'd16: reg16 <= wdata;
        5'd17: reg17 <= wdata;
        5'd18: reg18 <= wdata;
        5'd19: reg19 <= wdata;
        5'd20: reg20 <= wdata;
        5'd21: reg21 <= wdata;
        5'd22: reg22 <= wdata;
        5'd23: reg23 <= wdata;
        5'd24: reg24 <= wdata;
        5'd25: reg25 <= wdata;
        5'd26: reg26 <= wdata;
        5'd27: reg27 <= wdata;
        5'd28: reg28 <= wdata;
        5'd29: reg29 <= wdata;
        5'd30: reg30 <= wdata;
        5'd31: reg31 <= wdata;
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] read_reg(input logic [4:0] a);
    logic [31:0] v;
    case (a)
      5'd1:  v = reg1;
      5'd2:  v = reg2;
      5'd3:  v = reg3;
      5'd4:  v = reg4;
      5'd5:  v = reg5;
      5'd6:  v = reg6;
      5'd7:  v = reg7;
      5'd8:  v = reg8;
      5'd9:  v = reg9;
      5'd10: v = reg10;
      5'd11: v = reg11;
      5'd12: v = reg12;
      5'd13: v = reg13;
      5'd14: v = reg14;
      5'd15: v = reg15;
      5'd16: v = reg16;
      5'd17: v = reg17;
      5'd18: v = reg18;
      5'd19: v = reg19;
      5'd20: v = reg20;
      5'd21: v = reg21;
      5'd22: v = reg22;
      5'd23: v = reg23;
      5'd24: v = reg24;
      5'd25: v = reg25;
      5'd26: v = reg26;
      5'd27: v = reg27;
      5'd28: v = reg28;
      5'd29: v = reg29;
      5'd30: v = reg30;
      5'd31: v = reg31;
      default: v = reg0;
    endcase
    return v;
  endfunction

  always_comb begin
    rdata_a = read_reg(raddr_a);
    rdata_b = read_reg(raddr_b);
  end
endmodule

module unified_memory #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned AW        = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] iaddr,
  input  logic [AW-1:0] daddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   instr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:MEM_WORDS-1];

  assign instr = mem[iaddr];
  assign rdata = mem[daddr];

  always_ff @(posedge clk) begin
    if (we) mem[daddr] <= wdata;
  end
endmodule

module single_cycle_cpu #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned DATA_BASE = 2048
) (
  input logic clk,
  input logic reset
);
  // Address width must reach both the whole memory and the start of .data.
  localparam int unsigned AW = $clog2((MEM_WORDS > DATA_BASE) ? MEM_WORDS : DATA_BASE + 1);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW  = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR} alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;

  logic [31:0] PC = '0;
  logic [31:0] instruction;

  opcode_e     op;
  funct_e      funct;
  logic [4:0]  rs, rt, rd, waddr;
  logic [31:0] imm_sext, imm_zext, rs_data, rt_data, alu_b, alu_result, mem_rdata, wb_data;
  logic [31:0] pc_plus4, branch_target, jump_target, pc_next;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        alu_src_imm, imm_is_zext, reg_dst_rd, reg_write, mem_write;
  logic        is_beq, is_bne, is_jump, is_jr, is_link;
  logic        unused_bits;

  assign op       = opcode_e'(instruction[31:26]);
  assign funct    = funct_e'(instruction[5:0]);
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = instruction[15:11];
  assign imm_sext = {{16{instruction[15]}}, instruction[15:0]};
  assign imm_zext = {16'h0000, instruction[15:0]};
  assign unused_bits = ^{instruction[10:6], imm_sext[31:30]};

  always_comb begin
    alu_op      = ALU_ADD;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    imm_is_zext = 1'b0;
    reg_dst_rd  = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_jump     = 1'b0;
    is_jr       = 1'b0;
    is_link     = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_dst_rd = 1'b1;
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; reg_write = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; reg_write = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; reg_write = 1'b1; end
          FN_JR:  is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin alu_src_imm = 1'b1; reg_write = 1'b1; end
      OP_XORI: begin
        alu_src_imm = 1'b1;
        imm_is_zext = 1'b1;
        alu_op      = ALU_XOR;
        reg_write   = 1'b1;
      end
      OP_LW: begin alu_src_imm = 1'b1; reg_write = 1'b1; wb_sel = WB_MEM; end
      OP_SW: begin alu_src_imm = 1'b1; mem_write = 1'b1; end
      OP_BEQ: is_beq = 1'b1;
      OP_BNE: is_bne = 1'b1;
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin is_jump = 1'b1; is_link = 1'b1; reg_write = 1'b1; wb_sel = WB_LINK; end
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? (imm_is_zext ? imm_zext : imm_sext) : rt_data;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_SLT: alu_result = {31'b0, $signed(rs_data) < $signed(alu_b)};
      ALU_XOR: alu_result = rs_data ^ alu_b;
      default: alu_result = rs_data + alu_b;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_LINK: wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end

  assign waddr = is_link ? 5'd31 : (reg_dst_rd ? rd : rt);

  assign pc_plus4      = PC + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if ((is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data))
      pc_next = branch_target;
    else if (is_jump)
      pc_next = jump_target;
    else if (is_jr)
      pc_next = rs_data;
  end

  always_ff @(posedge clk) begin
    if (reset) PC <= '0;
    else       PC <= pc_next;
  end

  // Architectural writes are suppressed while reset holds PC at 0.
  regfile regfile (
    .clk     (clk),
    .we      (reg_write & ~reset),
    .waddr   (waddr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  unified_memory #(.MEM_WORDS(MEM_WORDS), .AW(AW)) MEMORY (
    .clk   (clk),
    .we    (mem_write & ~reset),
    .iaddr (PC[AW+1:2]),
    .daddr (alu_result[AW+1:2]),
    .wdata (rt_data),
    .instr (instruction),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed program-level checks for single_cycle_cpu using preloaded memory images.

module tb_single_cycle_cpu;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  single_cycle_cpu #(.MEM_WORDS(4096), .DATA_BASE(2048)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset, wipe the low text area and the probed data word, then leave reset at a negedge.
  task automatic begin_load();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.MEMORY.mem[i] = 32'h0000_0000;
    dut.MEMORY.mem[2049] = 32'h0000_0000;
  endtask

  task automatic end_load();
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;

    // ALU program
    begin_load();
    dut.MEMORY.mem[0] = 32'h2010_0005; // addi $16,$0,5
    dut.MEMORY.mem[1] = 32'h2011_0005; // addi $17,$0,5
    dut.MEMORY.mem[2] = 32'h0211_9022; // sub  $18,$16,$17
    dut.MEMORY.mem[3] = 32'h0211_9820; // add  $19,$16,$17
    dut.MEMORY.mem[4] = 32'h0211_A02A; // slt  $20,$16,$17
    dut.MEMORY.mem[5] = 32'h0800_0005; // j 20
    end_load();
    check("reset_pc", dut.PC, 32'd0);
    check("fetch0", dut.instruction, 32'h2010_0005);
    step(1);
    check("pc4", dut.PC, 32'd4);
    check("fetch1", dut.instruction, 32'h2011_0005);
    check("dep_reg16", dut.regfile.reg16, 32'd5);
    step(1);
    check("pc8", dut.PC, 32'd8);
    step(3);
    check("alu_pc", dut.PC, 32'd20);
    check("alu_reg17", dut.regfile.reg17, 32'd5);
    check("alu_reg18", dut.regfile.reg18, 32'd0);
    check("alu_reg19", dut.regfile.reg19, 32'd10);
    check("alu_reg20", dut.regfile.reg20, 32'd0);
    check("alu_reg21", dut.regfile.reg21, 32'd0);
    step(2);
    check("j_self", dut.PC, 32'd20);

    // Jump and link
    begin_load();
    dut.MEMORY.mem[0]  = 32'h2010_0005; // addi $16,$0,5
    dut.MEMORY.mem[1]  = 32'h2011_0014; // addi $17,$0,20
    dut.MEMORY.mem[2]  = 32'h0000_0000; // nop
    dut.MEMORY.mem[3]  = 32'h0C00_000A; // jal 40
    dut.MEMORY.mem[4]  = 32'h0800_0004; // j 16
    dut.MEMORY.mem[5]  = 32'h2014_0001; // addi $20,$0,1 (never reached)
    dut.MEMORY.mem[10] = 32'h0211_9020; // add  $18,$16,$17
    dut.MEMORY.mem[11] = 32'h2019_0014; // addi $25,$0,20
    dut.MEMORY.mem[12] = 32'h03E0_0008; // jr $31
    end_load();
    check("jal_reset_pc", dut.PC, 32'd0);
    step(3);
    check("jal_pc", dut.PC, 32'd12);
    step(1);
    check("jal_target", dut.PC, 32'd40);
    check("jal_reg31", dut.regfile.reg31, 32'd16);
    step(3);
    check("jr_return", dut.PC, 32'd16);
    check("fn_reg18", dut.regfile.reg18, 32'd25);
    check("fn_reg25", dut.regfile.reg25, 32'd20);
    check("fn_reg20", dut.regfile.reg20, 32'd0);

    // Branches
    begin_load();
    dut.MEMORY.mem[0] = 32'h2010_0005; // addi $16,$0,5
    dut.MEMORY.mem[1] = 32'h2011_0005; // addi $17,$0,5
    dut.MEMORY.mem[2] = 32'h2013_0000; // addi $19,$0,0
    dut.MEMORY.mem[3] = 32'h2012_0000; // addi $18,$0,0
    dut.MEMORY.mem[4] = 32'h1211_0001; // beq $16,$17,+1
    dut.MEMORY.mem[5] = 32'h2013_0001; // addi $19,$0,1 (skipped)
    dut.MEMORY.mem[6] = 32'h1611_0001; // bne $16,$17,+1
    dut.MEMORY.mem[7] = 32'h0211_9020; // add $18,$16,$17
    dut.MEMORY.mem[8] = 32'h1000_FFFF; // beq $0,$0,-1
    end_load();
    step(4);
    check("beq_pc", dut.PC, 32'd16);
    check("reg19_cleared", dut.regfile.reg19, 32'd0);
    step(1);
    check("beq_taken", dut.PC, 32'd24);
    step(1);
    check("bne_fallthru", dut.PC, 32'd28);
    step(2);
    check("beq_back", dut.PC, 32'd32);
    check("br_reg19", dut.regfile.reg19, 32'd0);
    check("br_reg18", dut.regfile.reg18, 32'd10);
    check("br_reg20", dut.regfile.reg20, 32'd0);

    // Memory, zero register, immediates
    begin_load();
    dut.MEMORY.mem[0] = 32'h2008_2000; // addi $8,$0,0x2000
    dut.MEMORY.mem[1] = 32'h2009_002A; // addi $9,$0,42
    dut.MEMORY.mem[2] = 32'hAD09_0004; // sw $9,4($8)
    dut.MEMORY.mem[3] = 32'h8D0A_0004; // lw $10,4($8)
    dut.MEMORY.mem[4] = 32'h2000_0007; // addi $0,$0,7
    dut.MEMORY.mem[5] = 32'h380B_FFFF; // xori $11,$0,0xFFFF
    dut.MEMORY.mem[6] = 32'h200C_FFFF; // addi $12,$0,-1
    dut.MEMORY.mem[7] = 32'h0180_682A; // slt $13,$12,$0
    dut.MEMORY.mem[8] = 32'h8D0E_0006; // lw $14,6($8) unaligned
    dut.MEMORY.mem[9] = 32'h1000_FFFF; // beq $0,$0,-1
    end_load();
    step(3);
    check("sw_mem2049", dut.MEMORY.mem[2049], 32'd42);
    step(6);
    check("mem_pc", dut.PC, 32'd36);
    check("lw_reg10", dut.regfile.reg10, 32'd42);
    check("zero_reg0", dut.regfile.reg0, 32'd0);
    check("xori_reg11", dut.regfile.reg11, 32'h0000_FFFF);
    check("addi_neg_reg12", dut.regfile.reg12, 32'hFFFF_FFFF);
    check("slt_signed_reg13", dut.regfile.reg13, 32'd1);
    check("lw_unaligned_reg14", dut.regfile.reg14, 32'd42);

    // Mid-run reset returns PC to 0 and leaves registers intact
    reset = 1'b1;
    step(1);
    check("rerun_reset_pc", dut.PC, 32'd0);
    check("reset_keeps_reg11", dut.regfile.reg11, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
